// File: rtl/step_dir_pkg.sv
// Shared definitions for the STEP/DIR generator: axis FSM encoding, direction codes, timer width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package step_dir_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    HIGH  = 2'd2,
    LOW   = 2'd3
  } axis_state_e;

  localparam logic DIR_POS = 1'b0;
  localparam logic DIR_NEG = 1'b1;

  // Wide enough for any realistic setup/high/low cycle count.
  localparam int CNT_W = 16;

endpackage

// File: rtl/step_axis_chan.sv
// One stepper axis: synchronise acc/dec strobes, queue one step, shape STEP/DIR, track position.
// Latency: strobe rise to STEP rise is 3 cycles, or 3+SETUP_CYC when DIR has to change.
// Backpressure: a one-deep slot absorbs a request while busy; a further request is dropped (overrun_o pulse).
// Ports: clk_i/rst_i (async, active-high); acc_i/dec_i async strobes; zero_pos_i sync clear;
//        step_o/dir_o/pos_o registered driver outputs; busy_o; overrun_o/conflict_o one-cycle error pulses.
module step_axis_chan
  import step_dir_pkg::*;
#(
  parameter int SETUP_CYC = 4,
  parameter int HIGH_CYC  = 8,
  parameter int LOW_CYC   = 8,
  parameter int POS_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             acc_i,
  input  logic             dec_i,
  input  logic             zero_pos_i,
  output logic             step_o,
  output logic             dir_o,
  output logic [POS_W-1:0] pos_o,
  output logic             busy_o,
  output logic             overrun_o,
  output logic             conflict_o
);

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] HIGH_LD  = CNT_W'(HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] LOW_LD   = CNT_W'(LOW_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);

  // [0],[1] are the synchroniser flops, [2] is the edge-detect history.
  logic [2:0]       acc_sync_q, dec_sync_q;
  logic             acc_rise, dec_rise;
  logic             req_vld_q, req_dir_q, conflict_q;

  axis_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             pend_vld_q, pend_vld_d;
  logic             pend_dir_q, pend_dir_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             step_q, busy_q, overrun_q, overrun_d;
  logic             dispatch, take, take_dir;

  assign acc_rise = acc_sync_q[1] & ~acc_sync_q[2];
  assign dec_rise = dec_sync_q[1] & ~dec_sync_q[2];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_sync_q <= '0;
      dec_sync_q <= '0;
      req_vld_q  <= 1'b0;
      req_dir_q  <= DIR_POS;
      conflict_q <= 1'b0;
    end else begin
      acc_sync_q <= {acc_sync_q[1:0], acc_i};
      dec_sync_q <= {dec_sync_q[1:0], dec_i};
      // Simultaneous acc and dec edges cancel each other and are flagged.
      req_vld_q  <= acc_rise ^ dec_rise;
      req_dir_q  <= dec_rise ? DIR_NEG : DIR_POS;
      conflict_q <= acc_rise & dec_rise;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dir_d      = dir_q;
    pend_vld_d = pend_vld_q;
    pend_dir_d = pend_dir_q;
    pos_d      = pos_q;
    overrun_d  = 1'b0;
    take       = 1'b0;
    take_dir   = pend_dir_q;

    // The last LOW cycle already counts as idle, so back-to-back steps keep
    // an exact HIGH_CYC+LOW_CYC period.
    dispatch = (state_q == IDLE) || ((state_q == LOW) && (cnt_q == '0));

    case (state_q)
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = HIGH;
          cnt_d   = HIGH_LD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      HIGH: begin
        if (cnt_q == '0) begin
          state_d = LOW;
          cnt_d   = LOW_LD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      LOW: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CNT_ONE;
      end
      default: ;
    endcase

    // Slot is older than a same-cycle request, so it is served first.
    if (dispatch) begin
      if (pend_vld_q) begin
        take       = 1'b1;
        take_dir   = pend_dir_q;
        pend_vld_d = 1'b0;
      end else if (req_vld_q) begin
        take     = 1'b1;
        take_dir = req_dir_q;
      end
    end

    if (take) begin
      if (take_dir == dir_q) begin
        state_d = HIGH;
        cnt_d   = HIGH_LD;
      end else begin
        dir_d   = take_dir;
        state_d = SETUP;
        cnt_d   = SETUP_LD;
      end
    end

    // A request not consumed directly goes to the slot, or is lost if the slot stays full.
    if (req_vld_q && !(dispatch && !pend_vld_q)) begin
      if (!pend_vld_d) begin
        pend_vld_d = 1'b1;
        pend_dir_d = req_dir_q;
      end else begin
        overrun_d = 1'b1;
      end
    end

    if ((state_d == HIGH) && (state_q != HIGH)) begin
      pos_d = (dir_d == DIR_NEG) ? (pos_q - POS_ONE) : (pos_q + POS_ONE);
    end
    if (zero_pos_i) pos_d = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dir_q      <= DIR_POS;
      pend_vld_q <= 1'b0;
      pend_dir_q <= DIR_POS;
      pos_q      <= '0;
      step_q     <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dir_q      <= dir_d;
      pend_vld_q <= pend_vld_d;
      pend_dir_q <= pend_dir_d;
      pos_q      <= pos_d;
      step_q     <= (state_d == HIGH);
      busy_q     <= (state_d != IDLE) | pend_vld_d | req_vld_q;
      overrun_q  <= overrun_d;
    end
  end

  assign step_o     = step_q;
  assign dir_o      = dir_q;
  assign pos_o      = pos_q;
  assign busy_o     = busy_q;
  assign overrun_o  = overrun_q;
  assign conflict_o = conflict_q;

endmodule

// File: rtl/step_dir_gen.sv
// Two-axis STEP/DIR generator from interpolator strobes, with sticky overrun/conflict flags.
// Latency: 3 cycles strobe-to-STEP (plus SETUP_CYC on a direction change); error flags 1 cycle after the event.
// Backpressure: none upstream; each axis buffers one step and drops further ones, setting overrun.
// Ports: sys_clk/sys_rst (async, active-high); X_/Y_acc/dec strobes; zero_pos, clr_err;
//        X_/Y_step, X_/Y_dir, X_/Y_pos driver outputs; busy; sticky overrun and conflict.
module step_dir_gen
  import step_dir_pkg::*;
#(
  parameter int SETUP_CYC = 4,
  parameter int HIGH_CYC  = 8,
  parameter int LOW_CYC   = 8,
  parameter int POS_W     = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             X_acc,
  input  logic             X_dec,
  input  logic             Y_acc,
  input  logic             Y_dec,
  input  logic             zero_pos,
  input  logic             clr_err,
  output logic             X_step,
  output logic             Y_step,
  output logic             X_dir,
  output logic             Y_dir,
  output logic [POS_W-1:0] X_pos,
  output logic [POS_W-1:0] Y_pos,
  output logic             busy,
  output logic             overrun,
  output logic             conflict
);

  logic x_busy, y_busy, x_ovr, y_ovr, x_cnf, y_cnf;
  logic overrun_q, conflict_q;

  step_axis_chan #(
    .SETUP_CYC(SETUP_CYC), .HIGH_CYC(HIGH_CYC), .LOW_CYC(LOW_CYC), .POS_W(POS_W)
  ) u_x_axis (
    .clk_i(sys_clk), .rst_i(sys_rst), .acc_i(X_acc), .dec_i(X_dec), .zero_pos_i(zero_pos),
    .step_o(X_step), .dir_o(X_dir), .pos_o(X_pos), .busy_o(x_busy),
    .overrun_o(x_ovr), .conflict_o(x_cnf)
  );

  step_axis_chan #(
    .SETUP_CYC(SETUP_CYC), .HIGH_CYC(HIGH_CYC), .LOW_CYC(LOW_CYC), .POS_W(POS_W)
  ) u_y_axis (
    .clk_i(sys_clk), .rst_i(sys_rst), .acc_i(Y_acc), .dec_i(Y_dec), .zero_pos_i(zero_pos),
    .step_o(Y_step), .dir_o(Y_dir), .pos_o(Y_pos), .busy_o(y_busy),
    .overrun_o(y_ovr), .conflict_o(y_cnf)
  );

  // A fresh error event beats a same-cycle clear so it is never lost.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      overrun_q  <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      if (x_ovr | y_ovr) overrun_q <= 1'b1;
      else if (clr_err)  overrun_q <= 1'b0;
      if (x_cnf | y_cnf) conflict_q <= 1'b1;
      else if (clr_err)  conflict_q <= 1'b0;
    end
  end

  assign busy     = x_busy | y_busy;
  assign overrun  = overrun_q;
  assign conflict = conflict_q;

endmodule

// File: tb/tb_step_dir_gen.sv
module tb_step_dir_gen;

  logic sys_clk = 1'b0;
  logic sys_rst, X_acc, X_dec, Y_acc, Y_dec, zero_pos, clr_err;
  logic X_step, Y_step, X_dir, Y_dir, busy, overrun, conflict;
  logic [15:0] X_pos, Y_pos;

  // Narrow-position instance used only for the signed wrap check.
  logic w_yacc;
  logic w_xstep, w_ystep, w_xdir, w_ydir, w_busy, w_ovr, w_cnf;
  logic [3:0] w_xpos, w_ypos;

  int total = 0;
  int bad   = 0;

  always #5 sys_clk = ~sys_clk;

  step_dir_gen dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .X_acc(X_acc), .X_dec(X_dec), .Y_acc(Y_acc), .Y_dec(Y_dec),
    .zero_pos(zero_pos), .clr_err(clr_err),
    .X_step(X_step), .Y_step(Y_step), .X_dir(X_dir), .Y_dir(Y_dir),
    .X_pos(X_pos), .Y_pos(Y_pos), .busy(busy), .overrun(overrun), .conflict(conflict)
  );

  step_dir_gen #(.POS_W(4)) dut4 (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .X_acc(1'b0), .X_dec(1'b0), .Y_acc(w_yacc), .Y_dec(1'b0),
    .zero_pos(1'b0), .clr_err(1'b0),
    .X_step(w_xstep), .Y_step(w_ystep), .X_dir(w_xdir), .Y_dir(w_ydir),
    .X_pos(w_xpos), .Y_pos(w_ypos), .busy(w_busy), .overrun(w_ovr), .conflict(w_cnf)
  );

  // Advance one clock; sample and drive 1 time unit after the rising edge.
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    X_acc = 0; X_dec = 0; Y_acc = 0; Y_dec = 0; zero_pos = 0; clr_err = 0; w_yacc = 0;
    repeat (3) tick();
    total++;
    if ({X_step, Y_step, X_dir, Y_dir, busy, overrun, conflict} !== 7'b0) begin
      bad++; $display("FAIL reset_flags: got %b want 0000000",
                      {X_step, Y_step, X_dir, Y_dir, busy, overrun, conflict});
    end
    total++;
    if (X_pos !== 16'h0 || Y_pos !== 16'h0) begin
      bad++; $display("FAIL reset_pos: got X=%h Y=%h want 0000", X_pos, Y_pos);
    end
    sys_rst = 1'b0;
    repeat (3) tick();
    total++;
    if ({X_step, Y_step, busy} !== 3'b0) begin
      bad++; $display("FAIL reset_idle: got %b want 000", {X_step, Y_step, busy});
    end
  endtask

  task automatic test_single_step();
    int rise_k = -1, fall_k = -1, hi = 0, busy_fall = -1, dir_bad = 0;
    X_acc = 1'b1;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (X_step && rise_k < 0) rise_k = k;
      if (X_step) hi++;
      if (!X_step && rise_k >= 0 && fall_k < 0) fall_k = k;
      if (rise_k >= 0 && !busy && busy_fall < 0) busy_fall = k;
      if (X_dir !== 1'b0) dir_bad++;
      if (k == 3) X_acc = 1'b0;
    end
    total++;
    if (rise_k !== 3) begin bad++; $display("FAIL single_rise: got %0d want 3", rise_k); end
    total++;
    if (hi !== 8) begin bad++; $display("FAIL single_width: got %0d want 8", hi); end
    total++;
    if (fall_k !== 11) begin bad++; $display("FAIL single_fall: got %0d want 11", fall_k); end
    total++;
    if (busy_fall !== 19) begin bad++; $display("FAIL single_busy: got %0d want 19", busy_fall); end
    total++;
    if (dir_bad !== 0) begin bad++; $display("FAIL single_dir: got %0d bad cycles want 0", dir_bad); end
    total++;
    if (X_pos !== 16'h0001 || Y_pos !== 16'h0000) begin
      bad++; $display("FAIL single_pos: got X=%h Y=%h want 0001 0000", X_pos, Y_pos);
    end
  endtask

  task automatic test_dir_change();
    int rises[3];
    int nrise = 0, dir_k = -1, xstep_seen = 0;
    logic prev = 1'b0;
    Y_dec = 1'b1;
    for (int k = 0; k < 70; k++) begin
      tick();
      if (Y_dir && dir_k < 0) dir_k = k;
      if (Y_step && !prev) begin
        if (nrise < 3) rises[nrise] = k;
        nrise++;
      end
      prev = Y_step;
      if (X_step) xstep_seen++;
      Y_dec = (((k + 1) % 20) < 2) && ((k + 1) < 60);
    end
    total++;
    if (nrise !== 3) begin bad++; $display("FAIL dir_nsteps: got %0d want 3", nrise); end
    total++;
    if (dir_k !== 3) begin bad++; $display("FAIL dir_rise: got %0d want 3", dir_k); end
    total++;
    if (rises[0] !== 7 || rises[1] !== 23 || rises[2] !== 43) begin
      bad++; $display("FAIL dir_step_times: got %0d %0d %0d want 7 23 43", rises[0], rises[1], rises[2]);
    end
    total++;
    if (Y_pos !== 16'hFFFD || Y_dir !== 1'b1) begin
      bad++; $display("FAIL dir_pos: got pos=%h dir=%b want FFFD 1", Y_pos, Y_dir);
    end
    total++;
    if (xstep_seen !== 0) begin bad++; $display("FAIL dir_x_quiet: got %0d want 0", xstep_seen); end
  endtask

  task automatic test_overrun();
    int rises[2];
    int nrise = 0, ovr_k = -1;
    logic prev = 1'b0;
    X_acc = 1'b1;
    for (int k = 0; k < 45; k++) begin
      tick();
      if (X_step && !prev) begin
        if (nrise < 2) rises[nrise] = k;
        nrise++;
      end
      prev = X_step;
      if (overrun && ovr_k < 0) ovr_k = k;
      X_acc = (k == 1) || (k == 5);
    end
    total++;
    if (nrise !== 2) begin bad++; $display("FAIL ovr_nsteps: got %0d want 2", nrise); end
    total++;
    if (rises[0] !== 3 || rises[1] !== 19) begin
      bad++; $display("FAIL ovr_step_times: got %0d %0d want 3 19", rises[0], rises[1]);
    end
    total++;
    if (ovr_k !== 10) begin bad++; $display("FAIL ovr_flag_time: got %0d want 10", ovr_k); end
    total++;
    if (X_pos !== 16'h0003 || overrun !== 1'b1) begin
      bad++; $display("FAIL ovr_pos: got pos=%h ovr=%b want 0003 1", X_pos, overrun);
    end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    total++;
    if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear: got %b want 0", overrun); end
  endtask

  task automatic test_conflict();
    int step_seen = 0, cnf_k = -1;
    X_acc = 1'b1; X_dec = 1'b1;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (X_step) step_seen++;
      if (conflict && cnf_k < 0) cnf_k = k;
      if (k == 2) begin X_acc = 1'b0; X_dec = 1'b0; end
    end
    total++;
    if (step_seen !== 0) begin bad++; $display("FAIL cnf_nostep: got %0d want 0", step_seen); end
    total++;
    if (cnf_k !== 3) begin bad++; $display("FAIL cnf_flag_time: got %0d want 3", cnf_k); end
    total++;
    if (X_pos !== 16'h0003 || X_dir !== 1'b0 || overrun !== 1'b0) begin
      bad++; $display("FAIL cnf_state: got pos=%h dir=%b ovr=%b want 0003 0 0", X_pos, X_dir, overrun);
    end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    total++;
    if (conflict !== 1'b0) begin bad++; $display("FAIL cnf_clear: got %b want 0", conflict); end
  endtask

  task automatic test_zero_pos();
    X_acc = 1'b1;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (k == 3) begin
        total++;
        if (X_step !== 1'b1 || X_pos !== 16'h0000 || Y_pos !== 16'h0000) begin
          bad++; $display("FAIL zero_same_cycle: got step=%b X=%h Y=%h want 1 0000 0000", X_step, X_pos, Y_pos);
        end
      end
      if (k == 1) X_acc = 1'b0;
      zero_pos = (k == 2);
    end
    total++;
    if (X_pos !== 16'h0000) begin bad++; $display("FAIL zero_hold: got %h want 0000", X_pos); end
  endtask

  task automatic test_wrap();
    Y_dec = 1'b1;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (k == 0) Y_dec = 1'b0;
    end
    total++;
    if (Y_pos !== 16'hFFFF) begin bad++; $display("FAIL wrap_below_zero: got %h want FFFF", Y_pos); end
    w_yacc = 1'b1;
    for (int k = 0; k < 160; k++) begin
      tick();
      if (k == 130) begin
        total++;
        if (w_ypos !== 4'h7) begin bad++; $display("FAIL wrap_max: got %h want 7", w_ypos); end
      end
      w_yacc = (((k + 1) % 20) == 0) && ((k + 1) < 160);
    end
    total++;
    if (w_ypos !== 4'h8 || w_ydir !== 1'b0) begin
      bad++; $display("FAIL wrap_signed: got pos=%h dir=%b want 8 0", w_ypos, w_ydir);
    end
  endtask

  task automatic test_reset_mid_pulse();
    int step_seen = 0, busy_seen = 0;
    X_acc = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      X_acc = (k == 1);
    end
    total++;
    if (X_step !== 1'b1 || X_pos !== 16'h0001 || busy !== 1'b1) begin
      bad++; $display("FAIL rstmid_pre: got step=%b pos=%h busy=%b want 1 0001 1", X_step, X_pos, busy);
    end
    #3 sys_rst = 1'b1;
    #1;
    total++;
    if (X_step !== 1'b0 || X_pos !== 16'h0000 || busy !== 1'b0) begin
      bad++; $display("FAIL rstmid_async: got step=%b pos=%h busy=%b want 0 0000 0", X_step, X_pos, busy);
    end
    repeat (2) tick();
    sys_rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (X_step) step_seen++;
      if (busy) busy_seen++;
    end
    total++;
    if (step_seen !== 0 || busy_seen !== 0) begin
      bad++; $display("FAIL rstmid_slot_cleared: got steps=%0d busy=%0d want 0 0", step_seen, busy_seen);
    end
  endtask

  initial begin
    test_reset();
    test_single_step();
    test_dir_change();
    test_overrun();
    test_conflict();
    test_zero_pos();
    test_wrap();
    test_reset_mid_pulse();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
